// File: rtl/idex_latch_if.sv
// ID/EX boundary bundle: decode-side fields and controls in, registered EX-side copies and status out.
interface idex_latch_if #(parameter int unsigned CNT_W = 32);
    // Controls from the hazard unit
    logic              en;
    logic              flush;

    // Decode-stage fields
    logic [5:0]        id_opfunc;
    logic [1:0]        id_RegDst;
    logic [1:0]        id_MemtoReg;
    logic [3:0]        id_ALUOp;
    logic [1:0]        id_ExtOp;
    logic              id_ALUSrc;
    logic              id_RegWEN;
    logic              id_dWENi;
    logic              id_dRENi;
    logic              id_taken;
    logic              id_datomic;
    logic              id_halt;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic [15:0]       id_imm;
    logic [25:0]       id_jaddr;
    logic [31:0]       id_busA;
    logic [31:0]       id_busB;
    logic [31:0]       id_npc;

    // Execute-stage registered copies
    logic [5:0]        ex_opfunc;
    logic [1:0]        ex_RegDst;
    logic [1:0]        ex_MemtoReg;
    logic [3:0]        ex_ALUOp;
    logic [1:0]        ex_ExtOp;
    logic              ex_ALUSrc;
    logic              ex_RegWEN;
    logic              ex_dWENi;
    logic              ex_dRENi;
    logic              ex_taken;
    logic              ex_datomic;
    logic              ex_halt;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [4:0]        ex_shamt;
    logic [15:0]       ex_imm;
    logic [25:0]       ex_jaddr;
    logic [31:0]       ex_busA;
    logic [31:0]       ex_busB;
    logic [31:0]       ex_npc;

    // Status
    logic              ex_valid;
    logic              halted;
    logic [CNT_W-1:0]  icount;

    modport master (
        output en, flush,
        output id_opfunc, id_RegDst, id_MemtoReg, id_ALUOp, id_ExtOp,
        output id_ALUSrc, id_RegWEN, id_dWENi, id_dRENi, id_taken, id_datomic, id_halt,
        output id_rs, id_rt, id_rd, id_shamt, id_imm, id_jaddr,
        output id_busA, id_busB, id_npc,
        input  ex_opfunc, ex_RegDst, ex_MemtoReg, ex_ALUOp, ex_ExtOp,
        input  ex_ALUSrc, ex_RegWEN, ex_dWENi, ex_dRENi, ex_taken, ex_datomic, ex_halt,
        input  ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm, ex_jaddr,
        input  ex_busA, ex_busB, ex_npc,
        input  ex_valid, halted, icount
    );

    modport slave (
        input  en, flush,
        input  id_opfunc, id_RegDst, id_MemtoReg, id_ALUOp, id_ExtOp,
        input  id_ALUSrc, id_RegWEN, id_dWENi, id_dRENi, id_taken, id_datomic, id_halt,
        input  id_rs, id_rt, id_rd, id_shamt, id_imm, id_jaddr,
        input  id_busA, id_busB, id_npc,
        output ex_opfunc, ex_RegDst, ex_MemtoReg, ex_ALUOp, ex_ExtOp,
        output ex_ALUSrc, ex_RegWEN, ex_dWENi, ex_dRENi, ex_taken, ex_datomic, ex_halt,
        output ex_rs, ex_rt, ex_rd, ex_shamt, ex_imm, ex_jaddr,
        output ex_busA, ex_busB, ex_npc,
        output ex_valid, halted, icount
    );
endinterface

// File: rtl/idex_latch.sv
// ID/EX pipeline register with stall, flush-to-bubble and halt-drain handling,
// plus a counter of valid instructions that entered EX.
module idex_latch #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        CLK,
    input  logic        RST,
    idex_latch_if.slave bus
);

    // Total width of the carried decode fields
    localparam int unsigned FW = 181;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic              load_id;
    logic              load_bubble;
    logic [FW-1:0]     id_f;
    logic [FW-1:0]     ex_q;
    logic              valid_q;
    logic              halted_q;
    logic [CNT_W-1:0]  icount_q;

    assign id_f = {bus.id_opfunc, bus.id_RegDst, bus.id_MemtoReg, bus.id_ALUOp, bus.id_ExtOp,
                   bus.id_ALUSrc, bus.id_RegWEN, bus.id_dWENi, bus.id_dRENi, bus.id_taken,
                   bus.id_datomic, bus.id_halt,
                   bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_imm, bus.id_jaddr,
                   bus.id_busA, bus.id_busB, bus.id_npc};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    // Flush outranks en, so a squashed halt never reaches HALTED
    always_comb begin
        state_nxt   = state;
        load_id     = 1'b0;
        load_bubble = 1'b0;
        case (state)
            RUN: begin
                if (bus.flush) begin
                    load_bubble = 1'b1;
                end else if (bus.en) begin
                    load_id = 1'b1;
                    if (bus.id_halt) state_nxt = HALTED;
                end
            end
            HALTED: begin
                load_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            icount_q <= '0;
        end else begin
            if (load_bubble) begin
                ex_q    <= '0;
                valid_q <= 1'b0;
            end else if (load_id) begin
                ex_q     <= id_f;
                valid_q  <= 1'b1;
                icount_q <= icount_q + CNT_W'(1);
            end
            // Registered copy of the next state so halted rises with ex_halt
            halted_q <= (state_nxt == HALTED);
        end
    end

    assign {bus.ex_opfunc, bus.ex_RegDst, bus.ex_MemtoReg, bus.ex_ALUOp, bus.ex_ExtOp,
            bus.ex_ALUSrc, bus.ex_RegWEN, bus.ex_dWENi, bus.ex_dRENi, bus.ex_taken,
            bus.ex_datomic, bus.ex_halt,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_imm, bus.ex_jaddr,
            bus.ex_busA, bus.ex_busB, bus.ex_npc} = ex_q;

    assign bus.ex_valid = valid_q;
    assign bus.halted   = halted_q;
    assign bus.icount   = icount_q;

endmodule

// File: tb/tb_idex_latch.sv
// Bench for idex_latch: directed scenarios plus random interleave, checked against a
// field-vector model every cycle; a CNT_W=4 copy shares the stimulus to exercise wrap.
module tb_idex_latch;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    idex_latch_if #(.CNT_W(32)) bus ();
    idex_latch_if #(.CNT_W(4))  bus4 ();

    idex_latch #(.CNT_W(32)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
    idex_latch #(.CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

    logic [180:0] tb_id;
    logic [180:0] dut_f;
    logic [180:0] dut4_f;

    assign tb_id = {bus.id_opfunc, bus.id_RegDst, bus.id_MemtoReg, bus.id_ALUOp, bus.id_ExtOp,
                    bus.id_ALUSrc, bus.id_RegWEN, bus.id_dWENi, bus.id_dRENi, bus.id_taken,
                    bus.id_datomic, bus.id_halt,
                    bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_imm, bus.id_jaddr,
                    bus.id_busA, bus.id_busB, bus.id_npc};

    assign dut_f = {bus.ex_opfunc, bus.ex_RegDst, bus.ex_MemtoReg, bus.ex_ALUOp, bus.ex_ExtOp,
                    bus.ex_ALUSrc, bus.ex_RegWEN, bus.ex_dWENi, bus.ex_dRENi, bus.ex_taken,
                    bus.ex_datomic, bus.ex_halt,
                    bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_imm, bus.ex_jaddr,
                    bus.ex_busA, bus.ex_busB, bus.ex_npc};

    assign dut4_f = {bus4.ex_opfunc, bus4.ex_RegDst, bus4.ex_MemtoReg, bus4.ex_ALUOp, bus4.ex_ExtOp,
                     bus4.ex_ALUSrc, bus4.ex_RegWEN, bus4.ex_dWENi, bus4.ex_dRENi, bus4.ex_taken,
                     bus4.ex_datomic, bus4.ex_halt,
                     bus4.ex_rs, bus4.ex_rt, bus4.ex_rd, bus4.ex_shamt, bus4.ex_imm, bus4.ex_jaddr,
                     bus4.ex_busA, bus4.ex_busB, bus4.ex_npc};

    // The narrow-counter copy sees exactly the same stimulus
    assign bus4.en    = bus.en;
    assign bus4.flush = bus.flush;
    assign {bus4.id_opfunc, bus4.id_RegDst, bus4.id_MemtoReg, bus4.id_ALUOp, bus4.id_ExtOp,
            bus4.id_ALUSrc, bus4.id_RegWEN, bus4.id_dWENi, bus4.id_dRENi, bus4.id_taken,
            bus4.id_datomic, bus4.id_halt,
            bus4.id_rs, bus4.id_rt, bus4.id_rd, bus4.id_shamt, bus4.id_imm, bus4.id_jaddr,
            bus4.id_busA, bus4.id_busB, bus4.id_npc} = tb_id;

    int unsigned nchk = 0;
    int unsigned nerr = 0;
    logic        chk_on = 1'b0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what EX must hold, derived from the boundary rules
    logic [180:0] m_f;
    logic         m_valid;
    logic         m_halted;
    int unsigned  m_cnt;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_f      <= '0;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_cnt    <= 0;
        end else if (m_halted || bus.flush) begin
            m_f     <= '0;
            m_valid <= 1'b0;
        end else if (bus.en) begin
            m_f     <= tb_id;
            m_valid <= 1'b1;
            m_cnt   <= m_cnt + 1;
            if (bus.id_halt) m_halted <= 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (!RST && chk_on) begin
            check("m_fields",  192'(dut_f),       192'(m_f));
            check("m_valid",   192'(bus.ex_valid), 192'(m_valid));
            check("m_halted",  192'(bus.halted),  192'(m_halted));
            check("m_icount",  192'(bus.icount),  192'(m_cnt));
            check("m_fields4", 192'(dut4_f),      192'(m_f));
            check("m_icount4", 192'(bus4.icount), 192'(m_cnt[3:0]));
        end
    end

    task automatic set_id(input logic [180:0] v);
        {bus.id_opfunc, bus.id_RegDst, bus.id_MemtoReg, bus.id_ALUOp, bus.id_ExtOp,
         bus.id_ALUSrc, bus.id_RegWEN, bus.id_dWENi, bus.id_dRENi, bus.id_taken,
         bus.id_datomic, bus.id_halt,
         bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_imm, bus.id_jaddr,
         bus.id_busA, bus.id_busB, bus.id_npc} = v;
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        bus.en    = 1'b0;
        bus.flush = 1'b0;
        #2 RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fields"}, 192'(dut_f),        192'(0));
        check({tag, "_valid"},  192'(bus.ex_valid), 192'(0));
        check({tag, "_halted"}, 192'(bus.halted),   192'(0));
        check({tag, "_icount"}, 192'(bus.icount),   192'(0));
        check({tag, "_icnt4"},  192'(bus4.icount),  192'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] r;
        bus.en    = 1'b0;
        bus.flush = 1'b0;
        set_id('0);
        #1;
        check_all_zero("rst_init");
        @(negedge CLK);
        RST    = 1'b0;
        chk_on = 1'b1;

        // Advance then stall for three cycles with different id values
        set_id('0);
        bus.id_busA = 32'h12345678; bus.id_rd = 5'd5; bus.id_RegWEN = 1'b1; bus.en = 1'b1;
        cyc();
        bus.en = 1'b0;
        bus.id_busA = 32'hFFFFFFFF; bus.id_rd = 5'd9; bus.id_RegWEN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("adv_busA",   192'(bus.ex_busA),   192'(32'h12345678));
            check("adv_rd",     192'(bus.ex_rd),     192'(5'd5));
            check("adv_RegWEN", 192'(bus.ex_RegWEN), 192'(1'b1));
            check("adv_valid",  192'(bus.ex_valid),  192'(1'b1));
            if (i < 3) cyc();
        end
        check("adv_icount", 192'(bus.icount), 192'(1));

        // Asynchronous reset mid-cycle with a live instruction held
        set_id('0); bus.id_busA = 32'hDEADBEEF; bus.en = 1'b1;
        cyc();
        bus.en = 1'b0;
        check("hold_busA", 192'(bus.ex_busA), 192'(32'hDEADBEEF));
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        cyc();
        check("rst_stall_valid", 192'(bus.ex_valid), 192'(0));
        check("rst_stall_busA",  192'(bus.ex_busA),  192'(0));
        bus.id_busA = 32'hA5A5A5A5; bus.en = 1'b1;
        cyc();
        check("post_rst_busA",  192'(bus.ex_busA), 192'(32'hA5A5A5A5));
        check("post_rst_valid", 192'(bus.ex_valid), 192'(1));
        check("post_rst_icount", 192'(bus.icount), 192'(1));

        // Flush outranks en, including a halt
        set_id('0); bus.id_dWENi = 1'b1; bus.id_halt = 1'b1; bus.en = 1'b1; bus.flush = 1'b1;
        cyc();
        check("flush_dWENi",  192'(bus.ex_dWENi), 192'(0));
        check("flush_halt",   192'(bus.ex_halt),  192'(0));
        check("flush_valid",  192'(bus.ex_valid), 192'(0));
        check("flush_halted", 192'(bus.halted),   192'(0));
        check("flush_icount", 192'(bus.icount),   192'(1));
        bus.flush = 1'b0; bus.id_halt = 1'b0; bus.id_dWENi = 1'b0; bus.id_busA = 32'h0BADF00D;
        cyc();
        check("after_flush_busA",   192'(bus.ex_busA), 192'(32'h0BADF00D));
        check("after_flush_icount", 192'(bus.icount),  192'(2));

        // Random interleave, halt held low
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            set_id(r[180:0]);
            bus.id_halt = 1'b0;
            bus.en      = 1'($urandom_range(0, 1));
            bus.flush   = ($urandom_range(0, 3) == 0);
            cyc();
        end

        // Counter wrap on the 4-bit copy
        do_reset();
        set_id('0);
        bus.en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.id_busA = 32'(i);
            cyc();
        end
        check("wrap_icount4", 192'(bus4.icount), 192'(4'd1));
        check("wrap_icount",  192'(bus.icount),  192'(17));
        check("wrap_busA4",   192'(bus4.ex_busA), 192'(16));

        // Halt drain
        do_reset();
        set_id('0); bus.id_halt = 1'b1; bus.en = 1'b1;
        cyc();
        check("halt_ex_halt", 192'(bus.ex_halt),  192'(1));
        check("halt_halted",  192'(bus.halted),   192'(1));
        check("halt_valid",   192'(bus.ex_valid), 192'(1));
        check("halt_icount",  192'(bus.icount),   192'(1));
        bus.id_halt = 1'b0; bus.id_RegWEN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("drain_ex_halt", 192'(bus.ex_halt),   192'(0));
            check("drain_halted",  192'(bus.halted),    192'(1));
            check("drain_valid",   192'(bus.ex_valid),  192'(0));
            check("drain_RegWEN",  192'(bus.ex_RegWEN), 192'(0));
            check("drain_icount",  192'(bus.icount),    192'(1));
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/idex_latch.md
# idex_latch

Decode-to-execute pipeline register for the 5-stage MIPS core. It captures every field the decode stage produces into the ID/EX boundary and presents it, registered, to the execute stage. It implements the stall, flush/bubble and halt-drain rules at that boundary, and keeps a retired-into-EX instruction counter for the bench.

## Interface
Parameters:
- CNT_W, 32, width of the instruction counter icount.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- en  in  1  advance: load the id_* fields on this edge.
- flush  in  1  squash: load a bubble on this edge.
- id_opfunc  in  opfunc_t  decoded opcode/function.
- id_RegDst  in  regdst_t  register destination select.
- id_MemtoReg  in  memtoreg_t  writeback source select.
- id_ALUOp  in  aluop_t  ALU operation.
- id_ExtOp  in  extop_t  immediate extension type.
- id_ALUSrc, id_RegWEN, id_dWENi, id_dRENi, id_taken, id_datomic, id_halt  in  1 each  control flags.
- id_rs, id_rt, id_rd  in  regbits_t (5) each  register specifiers.
- id_shamt  in  SHAM_W (5)  shift amount.
- id_imm  in  IMM_W (16)  immediate.
- id_jaddr  in  ADDR_W (26)  jump target field.
- id_busA, id_busB, id_npc  in  word_t (32) each  operand values and PC+4.
- ex_*  out  same set and widths as id_*  registered copies of the id_* fields.
- ex_valid  out  1  the EX slot holds a real instruction, not a bubble.
- halted  out  1  a halt has entered EX; the latch is draining or drained.
- icount  out  CNT_W  number of valid instructions loaded into EX since reset.

## Operation
A bubble has every ex_* field at 0 and ex_valid=0. In particular RegWEN, dWENi, dRENi, datomic, taken and halt are all 0, so a bubble causes no side effects.

State machine, two states:
- RUN (reset state).
- HALTED (left only by RST).

Edge behaviour in RUN, in priority order:
1. flush=1: load a bubble. This applies regardless of en.
2. en=1: load the id_* fields and set ex_valid=1. If id_halt=1, go to HALTED on the same edge.
3. en=0: hold all ex_* fields and ex_valid unchanged (stall).

Edge behaviour in HALTED:
- Load a bubble on every edge. en and flush are ignored.
- halted=1.
- Net effect: the halt instruction occupies EX for exactly one cycle, and nothing behind it ever enters EX.

Instruction counter:
- icount increments by 1 on every edge where a valid instruction is loaded (RUN, flush=0, en=1).
- It wraps modulo 2^CNT_W.
- A held (stalled) instruction is not counted again.

Other rules:
- No combinational path from any input to any output. Every output is a flop.
- Loads copy fields bit for bit. There is no masking of fields when en=1 and flush=0.

## Timing
- Latency: id_* sampled at edge N appears on ex_* after edge N and is stable for the whole cycle N..N+1.
- Reset: all outputs go to 0 immediately on RST, without waiting for CLK. This includes ex_valid=0, halted=0 and icount=0. State returns to RUN.
- Releasing RST mid-stall leaves a bubble in EX. The first en=1 edge afterwards loads normally.
- Simultaneous en=1 and flush=1 with id_halt=1: the result is a bubble, the state stays RUN and icount is unchanged. A squashed halt does not halt the core.
- halted rises on the same edge that ex_halt rises. ex_halt falls one edge later; halted stays high.
- Counter wrap: at icount = 2^CNT_W−1, a valid load gives icount = 0, with no other effect.

## Test plan
- Reset: assert RST mid-cycle with ex_busA=0xDEADBEEF held. Required: all outputs 0 immediately, before the next CLK edge.
- Advance and stall: en=1 with id_busA=0x12345678, id_rd=5, id_RegWEN=1, then en=0 for 3 cycles. Required: ex_busA=0x12345678, ex_rd=5, ex_RegWEN=1 and ex_valid=1 for 4 cycles; icount=1.
- Flush priority: en=1, flush=1, id_dWENi=1, id_halt=1. Required: ex_dWENi=0, ex_halt=0, ex_valid=0, halted=0, icount unchanged.
- Halt drain: en=1 with id_halt=1, then en=1 for 5 more edges with id_RegWEN=1. Required: ex_halt=1 for exactly one cycle, halted=1 from that edge onward, ex_valid=0 for the following 5 cycles, icount incremented by 1 only.
- Counter wrap: with CNT_W=4, perform 17 valid loads. Required: icount=1 after the 17th load.
- Random interleave: 1000 cycles of random en, flush and id_* values with id_halt=0. Required: ex_* match a reference model edge for edge; icount equals the count of (en & ~flush) edges.
